router_rr_drain: RTL

- Packet-atomic round-robin scheduler that shares one output port among the router's three per-destination FIFOs.
- Selects a non-empty FIFO and pops its header, payload and parity bytes onto a single valid/ready stream. It then moves the grant to the next requester.
- Drives a one-cycle soft-reset pulse to a FIFO whose packet stalls for too long, so that FIFO is flushed and the port is freed.

---
 rtl/router_rr_drain_if.sv | 45 ++++
 rtl/router_rr_drain.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/router_rr_drain_if.sv
// Signal bundle between the three destination FIFOs, the drain
// scheduler and the shared output stream.
interface router_rr_drain_if #(
    parameter int DATA_W = 8
);
    logic              empty_0;
    logic              empty_1;
    logic              empty_2;
    logic [DATA_W-1:0] dout_0;
    logic [DATA_W-1:0] dout_1;
    logic [DATA_W-1:0] dout_2;
    logic              rd_en_0;
    logic              rd_en_1;
    logic              rd_en_2;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;
    logic [1:0]        out_ch;
    logic              busy;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;

    modport master (
        input  empty_0, empty_1, empty_2,
        input  dout_0, dout_1, dout_2,
        input  out_ready,
        output rd_en_0, rd_en_1, rd_en_2,
        output out_data, out_valid, out_sop, out_eop,
        output out_ch, busy,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );

    modport slave (
        output empty_0, empty_1, empty_2,
        output dout_0, dout_1, dout_2,
        output out_ready,
        input  rd_en_0, rd_en_1, rd_en_2,
        input  out_data, out_valid, out_sop, out_eop,
        input  out_ch, busy,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );
endinterface

// File: rtl/router_rr_drain.sv
// Packet-atomic round-robin drain of three router FIFOs onto one
// valid/ready stream, with stall timeout and FIFO soft reset.
module router_rr_drain #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              reset,
    router_rr_drain_if.master bus
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [2:0]        srst_q, srst_d;
    logic [3:0]        empty_v;
    logic [DATA_W-1:0] dout_g;
    logic              empty_g;
    logic              valid;
    logic              xfer;
    logic              expire;
    logic [1:0]        c0, c1, c2;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Bit 3 pads the vector so a 2-bit index is always in range.
    assign empty_v = {1'b1, bus.empty_2, bus.empty_1, bus.empty_0};
    assign empty_g = empty_v[grant_q];

    always_comb begin
        dout_g = bus.dout_0;
        case (grant_q)
            2'd1:    dout_g = bus.dout_1;
            2'd2:    dout_g = bus.dout_2;
            default: dout_g = bus.dout_0;
        endcase
    end

    assign valid  = (state_q != IDLE) && !empty_g;
    assign xfer   = valid && bus.out_ready;
    assign expire = (state_q != IDLE) && !xfer &&
                    (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        srst_d   = '0;
        c0       = nxt(rr_ptr_q);
        c1       = nxt(c0);
        c2       = rr_ptr_q;

        if (state_q == IDLE || xfer) begin
            tmo_d = '0;
        end else if (tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (!empty_v[c0]) begin
                    grant_d = c0;
                    state_d = HEADER;
                end else if (!empty_v[c1]) begin
                    grant_d = c1;
                    state_d = HEADER;
                end else if (!empty_v[c2]) begin
                    grant_d = c2;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    cnt_d   = dout_g[7:2];
                    state_d = (dout_g[7:2] == 6'd0) ? PARITY : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 6'd1) state_d = PARITY;
                end
            end
            PARITY: begin
                if (xfer) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
        endcase

        // A stalled packet is abandoned and its FIFO flushed.
        if (expire) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
            tmo_d    = '0;
            srst_d   = 3'b001 << grant_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd2;
            grant_q  <= 2'd0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            srst_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            srst_q   <= srst_d;
        end
    end

    assign bus.out_data     = dout_g;
    assign bus.out_ch       = grant_q;
    assign bus.out_valid    = valid;
    assign bus.out_sop      = valid && (state_q == HEADER);
    assign bus.out_eop      = valid && (state_q == PARITY);
    assign bus.busy         = (state_q != IDLE);
    assign bus.rd_en_0      = xfer && (grant_q == 2'd0);
    assign bus.rd_en_1      = xfer && (grant_q == 2'd1);
    assign bus.rd_en_2      = xfer && (grant_q == 2'd2);
    assign bus.soft_reset_0 = srst_q[0];
    assign bus.soft_reset_1 = srst_q[1];
    assign bus.soft_reset_2 = srst_q[2];
endmodule
